// File: rtl/vram_arbiter.sv
// Purpose: owns the single-port 128x32 1bpp framebuffer RAM, one access per cycle, display > CPU > clear.
// Latency: display and CPU reads return data one cycle after the grant (disp_valid / cpu_rvalid pulse).
// Backpressure: display never stalls; CPU held off via cpu_ready while display reads; clear uses idle cycles.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   disp_req/disp_addr           scan-out read request (always granted)
//   disp_data/disp_valid         registered scan-out read data
//   cpu_valid/cpu_ready          CPU load/store handshake (cpu_we, cpu_addr, cpu_wdata, cpu_wstrb)
//   cpu_rdata/cpu_rvalid         registered CPU read data, single-cycle pulse
//   clr_start/clr_pattern        start a full-buffer fill with the given word
//   clr_busy/clr_done            fill in progress / pulse after the last word is written
// Build option: define VRAM_CLEAR_EN to include the clear engine. Without it clr_start and
// clr_pattern are ignored and clr_busy/clr_done stay 0.
module vram_arbiter #(
    parameter int WORDS = 128,
    parameter int AW    = $clog2(WORDS),
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            disp_req,
    input  logic [AW-1:0]   disp_addr,
    output logic [DW-1:0]   disp_data,
    output logic            disp_valid,
    input  logic            cpu_valid,
    output logic            cpu_ready,
    input  logic            cpu_we,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    input  logic [DW/8-1:0] cpu_wstrb,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_rvalid,
    input  logic            clr_start,
    input  logic [DW-1:0]   clr_pattern,
    output logic            clr_busy,
    output logic            clr_done
);

    logic [DW-1:0]   mem [WORDS];

    logic            cpu_go;
    logic            cpu_rd;
    logic            clr_wr;
    logic [AW-1:0]   clr_addr;
    logic [DW-1:0]   clr_pat;

    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW/8-1:0] ram_wstrb;
    logic [DW-1:0]   ram_rd;

    // CPU is only blocked by the display; the clear engine never holds it off.
    assign cpu_ready = cpu_valid & ~disp_req;
    assign cpu_go    = cpu_ready;
    assign cpu_rd    = cpu_go & ~cpu_we;

    // Single shared port: one address, one write enable per cycle.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wstrb = '0;
        if (disp_req) begin
            ram_addr = disp_addr;
        end else if (cpu_go) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_wstrb = cpu_wstrb;
        end else if (clr_wr) begin
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = clr_pat;
            ram_wstrb = '1;
        end
    end

    assign ram_rd = mem[ram_addr];

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (ram_wstrb[b]) begin
                    mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read data registers hold their last value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            disp_valid <= disp_req;
            cpu_rvalid <= cpu_rd;
            if (disp_req) begin
                disp_data <= ram_rd;
            end
            if (cpu_rd) begin
                cpu_rdata <= ram_rd;
            end
        end
    end

`ifdef VRAM_CLEAR_EN
    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_t;

    clr_state_t clr_state;

    // The fill only takes cycles nobody else wants, so its duration stretches under load.
    assign clr_wr = (clr_state == CLR_RUN) & ~disp_req & ~cpu_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_state <= CLR_IDLE;
            clr_addr  <= '0;
            clr_pat   <= '0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (clr_state)
                CLR_IDLE: begin
                    if (clr_start) begin
                        clr_pat   <= clr_pattern;
                        clr_addr  <= '0;
                        clr_busy  <= 1'b1;
                        clr_state <= CLR_RUN;
                    end
                end
                CLR_RUN: begin
                    // clr_start is ignored here: no restart while a fill is running.
                    if (clr_wr) begin
                        if (clr_addr == AW'(WORDS - 1)) begin
                            clr_busy  <= 1'b0;
                            clr_done  <= 1'b1;
                            clr_state <= CLR_IDLE;
                        end else begin
                            clr_addr <= clr_addr + 1'b1;
                        end
                    end
                end
                default: clr_state <= CLR_IDLE;
            endcase
        end
    end
`else
    logic unused_clr_inputs;

    assign clr_wr            = 1'b0;
    assign clr_addr          = '0;
    assign clr_pat           = '0;
    assign clr_busy          = 1'b0;
    assign clr_done          = 1'b0;
    assign unused_clr_inputs = ^{clr_start, clr_pattern};
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised scoreboard bench for vram_arbiter: a word-array reference model predicts every
// read response; a negedge monitor compares DUT outputs against the predictions.
`timescale 1ns/1ps
module tb_vram_arbiter;
    localparam int WORDS = 128;
    localparam int AW    = 7;
    localparam int DW    = 32;
`ifdef VRAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          cpu_valid;
    logic          cpu_ready;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [3:0]    cpu_wstrb;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          clr_start;
    logic [DW-1:0] clr_pattern;
    logic          clr_busy;
    logic          clr_done;

    always #5 clk = ~clk;

    vram_arbiter #(.WORDS(WORDS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .clr_start(clr_start), .clr_pattern(clr_pattern), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: plain word array plus a "next word to fill" counter.
    logic [31:0] mm [WORDS];
    logic [31:0] exp_disp[$];
    logic [31:0] exp_cpu[$];
    bit          m_active = 1'b0;
    int          m_next   = 0;
    logic [31:0] m_pat    = '0;

    // pend_* : expected outputs after the coming edge; cur_* : after the last edge.
    bit pend_dv = 0, pend_crv = 0, pend_busy = 0, pend_done = 0;
    bit cur_dv = 0, cur_crv = 0, cur_busy = 0, cur_done = 0;
    bit mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        disp_req    = 1'b0;
        disp_addr   = '0;
        cpu_valid   = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        cpu_wstrb   = '0;
        clr_start   = 1'b0;
        clr_pattern = '0;
    endtask

    // Called at posedge+1 with inputs already set: predicts this cycle, then advances one clock.
    task automatic step();
        bit was_active;
        was_active = m_active;
        pend_dv    = disp_req;
        pend_crv   = 1'b0;
        pend_done  = 1'b0;
        if (disp_req) begin
            exp_disp.push_back(mm[disp_addr]);
        end else if (cpu_valid) begin
            if (cpu_we) begin
                for (int b = 0; b < 4; b++)
                    if (cpu_wstrb[b]) mm[cpu_addr][8*b +: 8] = cpu_wdata[8*b +: 8];
            end else begin
                exp_cpu.push_back(mm[cpu_addr]);
                pend_crv = 1'b1;
            end
        end else if (m_active) begin
            mm[m_next] = m_pat;
            if (m_next == WORDS - 1) begin
                m_active  = 1'b0;
                pend_done = 1'b1;
            end else begin
                m_next++;
            end
        end
        if (CLR_EN && !was_active && clr_start) begin
            m_active = 1'b1;
            m_next   = 0;
            m_pat    = clr_pattern;
        end
        pend_busy = m_active;
        #1;
        check("cpu_ready", 32'(cpu_ready), 32'(cpu_valid & ~disp_req));
        @(posedge clk);
        #1;
        cur_dv   = pend_dv;
        cur_crv  = pend_crv;
        cur_busy = pend_busy;
        cur_done = pend_done;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        {cur_dv, cur_crv, cur_busy, cur_done}     = '0;
        {pend_dv, pend_crv, pend_busy, pend_done} = '0;
        exp_disp.delete();
        exp_cpu.delete();
        m_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < WORDS; i++) begin
            idle();
            cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(i);
            cpu_wdata = $urandom; cpu_wstrb = 4'hF;
            step();
        end
    endtask

    task automatic readback_all();
        for (int i = 0; i < WORDS; i++) begin
            idle();
            disp_req = 1'b1; disp_addr = AW'(i);
            step();
        end
    endtask

    // Monitor: per-cycle flag checks plus scoreboard pops on every presented read.
    always @(negedge clk) begin
        if (mon_en) begin
            check("disp_valid", 32'(disp_valid), 32'(cur_dv));
            check("cpu_rvalid", 32'(cpu_rvalid), 32'(cur_crv));
            check("clr_busy",   32'(clr_busy),   32'(cur_busy));
            check("clr_done",   32'(clr_done),   32'(cur_done));
            if (disp_valid) begin
                if (exp_disp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL disp_extra: got %h expected no response", disp_data);
                end else check("disp_data", disp_data, exp_disp.pop_front());
            end
            if (cpu_rvalid) begin
                if (exp_cpu.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cpu_extra: got %h expected no response", cpu_rdata);
                end else check("cpu_rdata", cpu_rdata, exp_cpu.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int stolen;
        bit hold;
        idle();
        do_reset();
        check("rst_disp_valid", 32'(disp_valid), 0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("rst_disp_data",  disp_data, 0);
        check("rst_cpu_rdata",  cpu_rdata, 0);
        check("rst_clr_busy",   32'(clr_busy), 0);
        check("rst_clr_done",   32'(clr_done), 0);

        fill_random();

        // Full write then read back.
        idle(); cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 7'd5;
        cpu_wdata = 32'hDEADBEEF; cpu_wstrb = 4'hF; step();
        idle(); cpu_valid = 1'b1; cpu_addr = 7'd5; step();
        check("t1_rvalid", 32'(cpu_rvalid), 1);
        check("t1_rdata", cpu_rdata, 32'hDEADBEEF);

        // Byte strobes.
        idle(); cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 7'd3;
        cpu_wdata = 32'h11223344; cpu_wstrb = 4'hF; step();
        idle(); cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 7'd3;
        cpu_wdata = 32'hAABBCCDD; cpu_wstrb = 4'b0101; step();
        idle(); cpu_valid = 1'b1; cpu_addr = 7'd3; step();
        check("t2_rdata", cpu_rdata, 32'h11BB33DD);

        // Display blocks the CPU for exactly the cycles it requests.
        idle(); disp_req = 1'b1; disp_addr = 7'd3; cpu_valid = 1'b1; cpu_addr = 7'd5; step();
        check("t3_disp_valid", 32'(disp_valid), 1);
        check("t3_cpu_stalled", 32'(cpu_rvalid), 0);
        check("t3_disp_data", disp_data, 32'h11BB33DD);
        disp_req = 1'b0; step();
        check("t3_cpu_rvalid", 32'(cpu_rvalid), 1);
        check("t3_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

        // Display read right after a CPU write sees the new word.
        idle(); cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 7'd7;
        cpu_wdata = 32'hCAFEF00D; cpu_wstrb = 4'hF; step();
        idle(); disp_req = 1'b1; disp_addr = 7'd7; step();
        check("raw_disp_data", disp_data, 32'hCAFEF00D);

`ifdef VRAM_CLEAR_EN
        // Clear on an idle bus: done exactly 128 cycles after start.
        idle(); clr_start = 1'b1; clr_pattern = 32'hFFFFFFFF; step();
        check("t4_busy", 32'(clr_busy), 1);
        idle();
        n = 0;
        while (!clr_done && n < 400) begin step(); n++; end
        check("t4_cycles", n, 128);
        readback_all();

        // Clear with periodic display steals and an ignored second start.
        idle(); clr_start = 1'b1; clr_pattern = 32'h0F0F0F0F; step();
        n = 0; stolen = 0;
        while (!clr_done && n < 600) begin
            idle();
            if (n % 10 == 0) begin disp_req = 1'b1; disp_addr = AW'(n % WORDS); stolen++; end
            if (n == 50) begin clr_start = 1'b1; clr_pattern = 32'h12345678; end
            step();
            n++;
        end
        check("t5_writes", n - stolen, 128);
        readback_all();

        // Reset mid-clear at word 40.
        fill_random();
        idle(); clr_start = 1'b1; clr_pattern = 32'hA5A5A5A5; step();
        idle();
        repeat (40) step();
        rst = 1'b1;
        #1;
        check("t6_busy_abort", 32'(clr_busy), 0);
        do_reset();
        readback_all();
`else
        // Without the clear engine a start request does nothing.
        idle(); clr_start = 1'b1; clr_pattern = 32'h0; step();
        check("noclr_busy", 32'(clr_busy), 0);
        idle();
        repeat (130) step();
        readback_all();
`endif

        // Randomised traffic; a stalled CPU request is held stable until accepted.
        hold = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            disp_req  = ($urandom_range(0, 9) < 3);
            disp_addr = AW'($urandom_range(0, WORDS - 1));
            if (!hold) begin
                cpu_valid = 1'($urandom_range(0, 1));
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = AW'($urandom_range(0, WORDS - 1));
                cpu_wdata = $urandom;
                cpu_wstrb = 4'($urandom_range(0, 15));
            end
            clr_start   = ($urandom_range(0, 99) == 0);
            clr_pattern = $urandom;
            hold = cpu_valid && disp_req;
            step();
        end
        idle();
        step();
        step();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("sb_disp_empty", 32'(exp_disp.size()), 0);
        check("sb_cpu_empty",  32'(exp_cpu.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
